mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx.sv | 137 +++++++++++++
 tb/tb_mmio_uart_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter with a 4-entry byte FIFO
// TXDATA at BASE_ADDR pushes a byte; STATUS at BASE_ADDR+4 reads {busy, full, empty}.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_F840,
  parameter int          CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        tx
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [31:0]     STAT_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             tx_nxt;

  logic [7:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       full, empty, busy, hit_data, push, pop, bit_end;
  logic       unused_bits;

  assign unused_bits = ^wdata[31:8];

  assign hit_data = (addr == BASE_ADDR);
  assign full     = (count == 3'd4);
  assign empty    = (count == 3'd0);
  assign busy     = (state != IDLE);
  assign push     = we & hit_data & ~full;
  assign stall    = we & hit_data & full;
  assign rdata    = (re && addr == STAT_ADDR) ? {29'b0, busy, full, empty} : 32'b0;
  assign bit_end  = (cnt == CNT_MAX);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        // pop uses the pre-edge count, so a byte pushed this edge waits a cycle
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          cnt_nxt   = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_nxt     = '0;
          bit_idx_nxt = 3'd0;
          state_nxt   = DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_idx_nxt = bit_idx + 3'd1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // line level follows the state being entered, so tx stays a clean register
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      tx      <= tx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= wdata[7:0];
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx
// Line expectations come from a frame-timing model: queue of bytes plus frame start cycle.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'hFFFF_F840;
  localparam logic [31:0] STAT  = 32'hFFFF_F844;
  localparam logic [31:0] OTHER = 32'h0000_1000;
  localparam int          CPB   = 4;
  localparam int          FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1, we = 1'b0, re = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] rdata;
  logic        stall, tx;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .stall(stall), .tx(tx)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  logic [7:0]  q[$];
  bit          active = 0, model_valid = 0;
  int          start_cyc = 0, cyc = 0;
  logic [7:0]  cur = 8'h0;
  logic        stall_seen;
  logic [31:0] rdata_seen;

  typedef struct {
    logic        rst, we, re;
    logic [31:0] addr, wdata, rdata;
    logic        stall, tx;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic m_busy();
    return active && (cyc - start_cyc) < FRAME;
  endfunction

  function automatic logic m_tx();
    int pos;
    if (!m_busy()) return 1'b1;
    pos = (cyc - start_cyc) / CPB;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return cur[pos-1];
  endfunction

  function automatic logic [31:0] m_rdata();
    if (re && addr == STAT) return {29'b0, m_busy(), q.size() == 4, q.size() == 0};
    return 32'h0;
  endfunction

  function automatic logic m_stall();
    return we && addr == BASE && q.size() == 4;
  endfunction

  task automatic model_edge();
    bit was_busy, do_pop, do_push;
    cyc++;
    if (rst) begin
      q.delete();
      active      = 0;
      model_valid = 1;
    end else begin
      was_busy = active && (cyc - start_cyc) <= FRAME;
      do_pop   = !was_busy && q.size() > 0;
      do_push  = we && addr == BASE && q.size() < 4;
      if (!was_busy) active = 0;
      if (do_pop) begin
        cur       = q.pop_front();
        active    = 1;
        start_cyc = cyc;
      end
      if (do_push) q.push_back(wdata[7:0]);
    end
  endtask

  // entered just after a negedge; leaves at the next negedge
  task automatic do_cycle(input logic r, input logic w, input logic rd,
                          input logic [31:0] a, input logic [31:0] d);
    rst = r; we = w; re = rd; addr = a; wdata = d;
    #1;
    stall_seen = stall;
    rdata_seen = rdata;
    if (model_valid) begin
      check("model_stall", stall, m_stall());
      check("model_rdata", rdata, m_rdata());
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("model_tx", tx, m_tx());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [9:0] frame55;
    int p, n, bad;
    logic first_stall;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, STAT,   32'h0,  32'h1, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, STAT,   32'h0,  32'h1, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, BASE,   32'h0,  32'h0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, OTHER,  32'h0,  32'h0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, STAT,   32'h0,  32'h0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, STAT,   32'h99, 32'h0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, OTHER,  32'h77, 32'h0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, STAT,   32'h0,  32'h1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, BASE,   32'h33, 32'h0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, STAT,   32'h0,  32'h1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0,  32'h0, 1'b0, 1'b1};

    @(negedge clk);
    foreach (tbl[i]) begin
      do_cycle(tbl[i].rst, tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata);
      check($sformatf("tbl%0d_stall", i), stall_seen, tbl[i].stall);
      check($sformatf("tbl%0d_rdata", i), rdata_seen, tbl[i].rdata);
      check($sformatf("tbl%0d_tx", i), tx, tbl[i].tx);
    end

    // single byte 0x55: start, LSB-first data, stop, each CPB cycles
    frame55 = {1'b1, 8'h55, 1'b0};
    do_cycle(1'b0, 1'b1, 1'b0, BASE, 32'hABCD_0055);
    check("single_accept_tx", tx, 1'b1);
    bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      idle(1);
      if (tx !== frame55[i / CPB]) bad++;
    end
    check("single_frame_bad_cycles", bad, 0);
    idle(2);
    check("single_idle_tx", tx, 1'b1);
    do_cycle(1'b0, 1'b0, 1'b1, STAT, 32'h0);
    check("single_status", rdata_seen, 32'h1);

    // back-pressure: 0x41..0x45 accepted, 0x46 stalls until 0x42 pops
    p = 0;
    for (int b = 0; b < 5; b++) begin
      do_cycle(1'b0, 1'b1, 1'b0, BASE, 32'h41 + b);
      check($sformatf("bp_stall_w%0d", b + 1), stall_seen, 1'b0);
      if (b == 1) p = cyc;
    end
    do_cycle(1'b0, 1'b0, 1'b1, STAT, 32'h0);
    check("bp_status_full", rdata_seen, 32'h6);
    n = 0;
    first_stall = 1'b0;
    do begin
      do_cycle(1'b0, 1'b1, 1'b0, BASE, 32'h46);
      if (n == 0) first_stall = stall_seen;
      n++;
    end while (stall_seen && n < 100);
    check("bp_stall_w6", first_stall, 1'b1);
    check("bp_clear_delay", cyc - 1 - p, 41);
    idle(6 * (FRAME + 1) + 4);
    do_cycle(1'b0, 1'b0, 1'b1, STAT, 32'h0);
    check("bp_drained_status", rdata_seen, 32'h1);

    // busy status during the data phase
    do_cycle(1'b0, 1'b1, 1'b0, BASE, 32'h7E);
    idle(1 + 3 * CPB);
    do_cycle(1'b0, 1'b0, 1'b1, STAT, 32'h0);
    check("busy_status", rdata_seen, 32'h5);
    do_cycle(1'b0, 1'b0, 1'b1, BASE, 32'h0);
    check("busy_read_base", rdata_seen, 32'h0);
    do_cycle(1'b0, 1'b0, 1'b1, OTHER, 32'h0);
    check("busy_read_other", rdata_seen, 32'h0);
    idle(FRAME);

    // reset during data bit 3 drops the frame and the queued 0xFF
    do_cycle(1'b0, 1'b1, 1'b0, BASE, 32'h00);
    do_cycle(1'b0, 1'b1, 1'b0, BASE, 32'hFF);
    idle(4 * CPB + 1);
    check("rst_pre_tx_low", tx, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("rst_mid_tx", tx, 1'b1);
    bad = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle(1);
      if (tx !== 1'b1) bad++;
    end
    check("rst_line_stays_high", bad, 0);
    do_cycle(1'b0, 1'b0, 1'b1, STAT, 32'h0);
    check("rst_status", rdata_seen, 32'h1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic r, w, rd;
      logic [31:0] a;
      int sel;
      r   = ($urandom_range(0, 399) == 0);
      w   = ($urandom_range(0, 9) < 3);
      rd  = $urandom_range(0, 1);
      sel = $urandom_range(0, 3);
      a   = (sel < 2) ? BASE : (sel == 2) ? STAT : $urandom;
      do_cycle(r, w, rd, a, $urandom);
    end
    idle(5 * (FRAME + 1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
